// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the dproc pipeline control blocks.
// The hazard controller uses the FSM state type and the scoreboard counter helper.
package ecap5_dproc_pkg;

   localparam int HZD_CNT_WIDTH       = 2;
   localparam int HZD_FLUSH_CNT_WIDTH = 3;

   typedef enum logic [0:0] {
      HZD_RUN   = 1'b0,
      HZD_FLUSH = 1'b1
   } hazard_state_t;

   // Net effect of one cycle on a pending-write counter; an increment and a
   // decrement in the same cycle cancel, and the count neither wraps nor underflows.
   function automatic logic [HZD_CNT_WIDTH-1:0] hzd_cnt_next(
      input logic [HZD_CNT_WIDTH-1:0] cnt,
      input logic                     inc,
      input logic                     dec
   );
      logic [HZD_CNT_WIDTH-1:0] nxt;
      nxt = cnt;
      if (inc && !dec && (cnt != '1)) begin
         nxt = cnt + HZD_CNT_WIDTH'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         nxt = cnt - HZD_CNT_WIDTH'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters for x1..x31 with two source read ports,
// a destination-full check and a sticky error for retires with nothing pending.
module hazard_scoreboard
   import ecap5_dproc_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   input  logic [4:0] inc_addr_i,
   input  logic       dec_i,
   input  logic [4:0] dec_addr_i,
   input  logic [4:0] rs1_addr_i,
   input  logic [4:0] rs2_addr_i,
   input  logic [4:0] rd_addr_i,
   output logic       rs1_busy_o,
   output logic       rs2_busy_o,
   output logic       rd_full_o,
   output logic       err_o
);

   logic [HZD_CNT_WIDTH-1:0] cnt_q [32];
   logic [HZD_CNT_WIDTH-1:0] cnt_d [32];
   logic                     err_q;
   logic                     err_d;
   logic                     inc_x;
   logic                     dec_x;

   // Entry 0 exists only so that 5-bit addresses index directly; it stays zero.
   assign inc_x = inc_i && (inc_addr_i != 5'd0);
   assign dec_x = dec_i && (dec_addr_i != 5'd0);

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < 32; i++) begin
         cnt_d[i] = hzd_cnt_next(cnt_q[i],
                                 inc_x && (inc_addr_i == 5'(i)),
                                 dec_x && (dec_addr_i == 5'(i)));
      end
      cnt_d[0] = '0;
      if (dec_x && (cnt_q[dec_addr_i] == '0) &&
          !(inc_x && (inc_addr_i == dec_addr_i))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            cnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         err_q <= err_d;
      end
   end

   assign rs1_busy_o = (rs1_addr_i != 5'd0) && (cnt_q[rs1_addr_i] != '0);
   assign rs2_busy_o = (rs2_addr_i != 5'd0) && (cnt_q[rs2_addr_i] != '0);
   assign rd_full_o  = (rd_addr_i != 5'd0) &&
                       (cnt_q[rd_addr_i] == HZD_CNT_WIDTH'(MAX_INFLIGHT));
   assign err_o      = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/flush sequencing for the in-order core: stalls decode on pending writes
// and redirects fetch with a fixed-length front-end flush on taken branches.
module hazard_ctrl
   import ecap5_dproc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic        rs1_used_i,
   input  logic [4:0]  rs2_addr_i,
   input  logic        rs2_used_i,
   input  logic        rd_write_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        retire_i,
   input  logic [4:0]  retire_addr_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        jump_o,
   output logic [31:0] jump_target_o,
   output logic        err_o
);

   localparam logic [HZD_FLUSH_CNT_WIDTH-1:0] FLUSH_RELOAD =
      HZD_FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

   hazard_state_t                  state_q, state_d;
   logic [HZD_FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                           jump_q, jump_d;
   logic [31:0]                    jump_target_q, jump_target_d;
   logic                           sb_inc;
   logic                           rs1_busy, rs2_busy, rd_full;

   // issue_i is the decode->exm transfer (valid && ready in the same cycle); it
   // is only legal while stall_o is low, and instructions transferred while the
   // front end is being flushed are squashed, so they never reserve a register.
   assign sb_inc = issue_i && rd_write_i && !flush_o;

   hazard_scoreboard #(
      .MAX_INFLIGHT(MAX_INFLIGHT)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (sb_inc),
      .inc_addr_i (rd_addr_i),
      .dec_i      (retire_i),
      .dec_addr_i (retire_addr_i),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rd_addr_i  (rd_addr_i),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .rd_full_o  (rd_full),
      .err_o      (err_o)
   );

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      jump_d        = 1'b0;
      jump_target_d = jump_target_q;
      if (branch_i) begin
         // A branch in either state restarts the flush; the latest target wins.
         state_d       = HZD_FLUSH;
         flush_cnt_d   = FLUSH_RELOAD;
         jump_d        = 1'b1;
         jump_target_d = branch_target_i;
      end else if (state_q == HZD_FLUSH) begin
         if (flush_cnt_q == '0) begin
            state_d = HZD_RUN;
         end else begin
            flush_cnt_d = flush_cnt_q - HZD_FLUSH_CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= HZD_RUN;
         flush_cnt_q   <= '0;
         jump_q        <= 1'b0;
         jump_target_q <= '0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         jump_q        <= jump_d;
         jump_target_q <= jump_target_d;
      end
   end

   assign flush_o       = (state_q == HZD_FLUSH);
   assign jump_o        = jump_q;
   assign jump_target_o = jump_target_q;
   assign stall_o       = flush_o ||
                          (rs1_used_i && rs1_busy) ||
                          (rs2_used_i && rs2_busy) ||
                          (rd_write_i && rd_full);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, async reset mid-flush, then
// randomized traffic checked against a counting reference model.
module tb_hazard_ctrl;

   localparam int FC = 2;
   localparam int MI = 3;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        issue_i;
   logic [4:0]  rs1_addr_i;
   logic        rs1_used_i;
   logic [4:0]  rs2_addr_i;
   logic        rs2_used_i;
   logic        rd_write_i;
   logic [4:0]  rd_addr_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        retire_i;
   logic [4:0]  retire_addr_i;
   logic        stall_o;
   logic        flush_o;
   logic        jump_o;
   logic [31:0] jump_target_o;
   logic        err_o;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .FLUSH_CYCLES(FC),
      .MAX_INFLIGHT(MI)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .issue_i         (issue_i),
      .rs1_addr_i      (rs1_addr_i),
      .rs1_used_i      (rs1_used_i),
      .rs2_addr_i      (rs2_addr_i),
      .rs2_used_i      (rs2_used_i),
      .rd_write_i      (rd_write_i),
      .rd_addr_i       (rd_addr_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .retire_i        (retire_i),
      .retire_addr_i   (retire_addr_i),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .jump_o          (jump_o),
      .jump_target_o   (jump_target_o),
      .err_o           (err_o)
   );

   typedef struct {
      logic        issue;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic        rdw;
      logic [4:0]  rd;
      logic        br;
      logic [31:0] tgt;
      logic        ret;
      logic [4:0]  raddr;
      logic        e_stall;
      logic        e_flush;
      logic        e_jump;
      logic [31:0] e_tgt;
      logic        e_err;
   } vec_t;

   vec_t        vecs[$];
   logic [35:0] exp_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;

   // Reference model: pending-write counts per register and remaining flush cycles.
   int          cnt_m[32];
   int          flush_left;
   logic        jump_m;
   logic [31:0] tgt_m;
   logic        err_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      flush_left = 0;
      jump_m     = 1'b0;
      tgt_m      = '0;
      err_m      = 1'b0;
   endtask

   function automatic logic model_stall();
      return (flush_left > 0) ||
             (rs1_used_i && rs1_addr_i != 0 && cnt_m[rs1_addr_i] > 0) ||
             (rs2_used_i && rs2_addr_i != 0 && cnt_m[rs2_addr_i] > 0) ||
             (rd_write_i && rd_addr_i != 0 && cnt_m[rd_addr_i] >= MI);
   endfunction

   task automatic model_edge();
      bit inc, dec;
      inc = issue_i && rd_write_i && rd_addr_i != 0 && flush_left == 0;
      dec = retire_i && retire_addr_i != 0;
      if (!(inc && dec && rd_addr_i == retire_addr_i)) begin
         if (inc && cnt_m[rd_addr_i] < 3) cnt_m[rd_addr_i]++;
         if (dec) begin
            if (cnt_m[retire_addr_i] == 0) err_m = 1'b1;
            else cnt_m[retire_addr_i]--;
         end
      end
      if (branch_i) begin
         jump_m     = 1'b1;
         tgt_m      = branch_target_i;
         flush_left = FC;
      end else begin
         jump_m = 1'b0;
         if (flush_left > 0) flush_left--;
      end
   endtask

   task automatic drive_idle();
      issue_i = 0; rs1_addr_i = 0; rs1_used_i = 0; rs2_addr_i = 0; rs2_used_i = 0;
      rd_write_i = 0; rd_addr_i = 0; branch_i = 0; branch_target_i = 0;
      retire_i = 0; retire_addr_i = 0;
   endtask

   task automatic add(input logic is, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic w,
                      input logic [4:0] rd, input logic b, input logic [31:0] t,
                      input logic rt, input logic [4:0] ra, input logic es,
                      input logic ef, input logic ej, input logic [31:0] et,
                      input logic ee);
      vec_t v;
      v.issue = is; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2; v.rdw = w;
      v.rd = rd; v.br = b; v.tgt = t; v.ret = rt; v.raddr = ra;
      v.e_stall = es; v.e_flush = ef; v.e_jump = ej; v.e_tgt = et; v.e_err = ee;
      vecs.push_back(v);
   endtask

   task automatic table_step(input vec_t v, input int idx);
      issue_i = v.issue; rs1_addr_i = v.rs1; rs1_used_i = v.u1; rs2_addr_i = v.rs2;
      rs2_used_i = v.u2; rd_write_i = v.rdw; rd_addr_i = v.rd; branch_i = v.br;
      branch_target_i = v.tgt; retire_i = v.ret; retire_addr_i = v.raddr;
      @(negedge clk);
      check($sformatf("vec%0d_stall", idx), 32'(stall_o), 32'(v.e_stall));
      check($sformatf("vec%0d_flush", idx), 32'(flush_o), 32'(v.e_flush));
      check($sformatf("vec%0d_jump", idx), 32'(jump_o), 32'(v.e_jump));
      check($sformatf("vec%0d_target", idx), jump_target_o, v.e_tgt);
      check($sformatf("vec%0d_err", idx), 32'(err_o), 32'(v.e_err));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step(input string tag);
      logic [35:0] e;
      @(negedge clk);
      exp_q.push_back({model_stall(), flush_left > 0, jump_m, err_m, tgt_m});
      e = exp_q.pop_front();
      check({tag, "_stall"}, 32'(stall_o), 32'(e[35]));
      check({tag, "_flush"}, 32'(flush_o), 32'(e[34]));
      check({tag, "_jump"}, 32'(jump_o), 32'(e[33]));
      check({tag, "_err"}, 32'(err_o), 32'(e[32]));
      check({tag, "_target"}, jump_target_o, e[31:0]);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      // RAW hazard, release one cycle after retire
      add(1, 0,1, 0,0, 1,5,  0,0,        0,0,  0,0,0,32'h0,0);
      add(0, 5,1, 0,0, 0,0,  0,0,        0,0,  1,0,0,32'h0,0);
      add(0, 5,1, 0,0, 0,0,  0,0,        1,5,  1,0,0,32'h0,0);
      add(1, 5,1, 0,0, 0,0,  0,0,        0,0,  0,0,0,32'h0,0);
      // x0 is never tracked
      add(1, 0,1, 0,0, 1,0,  0,0,        0,0,  0,0,0,32'h0,0);
      add(1, 0,1, 0,1, 0,0,  0,0,        0,0,  0,0,0,32'h0,0);
      // simultaneous issue and retire of x7
      add(1, 0,0, 0,0, 1,7,  0,0,        0,0,  0,0,0,32'h0,0);
      add(1, 0,0, 0,0, 1,7,  0,0,        1,7,  0,0,0,32'h0,0);
      add(0, 0,0, 7,1, 0,0,  0,0,        0,0,  1,0,0,32'h0,0);
      add(0, 0,0, 7,1, 0,0,  0,0,        1,7,  1,0,0,32'h0,0);
      add(0, 0,0, 7,1, 0,0,  0,0,        0,0,  0,0,0,32'h0,0);
      // saturation of x3
      add(1, 0,0, 0,0, 1,3,  0,0,        0,0,  0,0,0,32'h0,0);
      add(1, 0,0, 0,0, 1,3,  0,0,        0,0,  0,0,0,32'h0,0);
      add(1, 0,0, 0,0, 1,3,  0,0,        0,0,  0,0,0,32'h0,0);
      add(0, 0,0, 0,0, 1,3,  0,0,        0,0,  1,0,0,32'h0,0);
      add(0, 0,0, 0,0, 1,3,  0,0,        1,3,  1,0,0,32'h0,0);
      add(0, 0,0, 0,0, 1,3,  0,0,        0,0,  0,0,0,32'h0,0);
      // single branch, issues during flush are ignored
      add(0, 0,0, 0,0, 0,0,  1,32'h1040, 0,0,  0,0,0,32'h0,0);
      add(1, 0,0, 0,0, 1,10, 0,0,        0,0,  1,1,1,32'h1040,0);
      add(1, 0,0, 0,0, 1,10, 0,0,        0,0,  1,1,0,32'h1040,0);
      add(0, 10,1,0,0, 0,0,  0,0,        0,0,  0,0,0,32'h1040,0);
      // back-to-back branches, retire during flush
      add(0, 0,0, 0,0, 0,0,  1,32'h3000, 0,0,  0,0,0,32'h1040,0);
      add(0, 0,0, 0,0, 0,0,  1,32'h2000, 0,0,  1,1,1,32'h3000,0);
      add(0, 0,0, 0,0, 0,0,  0,0,        1,3,  1,1,1,32'h2000,0);
      add(0, 0,0, 0,0, 0,0,  0,0,        0,0,  1,1,0,32'h2000,0);
      add(0, 0,0, 0,0, 0,0,  0,0,        0,0,  0,0,0,32'h2000,0);
      // sticky error on retire with nothing pending
      add(0, 0,0, 0,0, 0,0,  0,0,        1,9,  0,0,0,32'h2000,0);
      add(0, 0,0, 0,0, 0,0,  0,0,        0,0,  0,0,0,32'h2000,1);
      add(0, 0,0, 0,0, 0,0,  0,0,        1,3,  0,0,0,32'h2000,1);
      add(0, 0,0, 0,0, 1,3,  0,0,        0,0,  0,0,0,32'h2000,1);

      drive_idle();
      rst_i = 1'b1;
      model_reset();
      @(negedge clk);
      check("reset_stall", 32'(stall_o), 32'h0);
      check("reset_flush", 32'(flush_o), 32'h0);
      check("reset_jump", 32'(jump_o), 32'h0);
      check("reset_target", jump_target_o, 32'h0);
      check("reset_err", 32'(err_o), 32'h0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) table_step(vecs[i], i);

      // asynchronous reset in the middle of a flush
      drive_idle();
      branch_i = 1'b1;
      branch_target_i = 32'h0000_0055;
      @(posedge clk);
      #1;
      branch_i = 1'b0;
      check("midflush_flush", 32'(flush_o), 32'h1);
      check("midflush_jump", 32'(jump_o), 32'h1);
      #2;
      rst_i = 1'b1;
      #1;
      check("async_rst_stall", 32'(stall_o), 32'h0);
      check("async_rst_flush", 32'(flush_o), 32'h0);
      check("async_rst_jump", 32'(jump_o), 32'h0);
      check("async_rst_target", jump_target_o, 32'h0);
      check("async_rst_err", 32'(err_o), 32'h0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      model_reset();
      issue_i = 1'b1; rs1_used_i = 1'b1; rs2_used_i = 1'b1;
      step("post_rst");

      for (int c = 0; c < 500; c++) begin
         int cand[$];
         drive_idle();
         rs1_addr_i = 5'($urandom_range(0, 7));
         rs1_used_i = 1'($urandom_range(0, 1));
         rs2_addr_i = 5'($urandom_range(0, 7));
         rs2_used_i = 1'($urandom_range(0, 1));
         rd_write_i = 1'($urandom_range(0, 1));
         rd_addr_i  = 5'($urandom_range(0, 7));
         branch_i   = ($urandom_range(0, 11) == 0);
         branch_target_i = $urandom;
         issue_i    = ($urandom_range(0, 2) != 0) && !model_stall();
         for (int r = 1; r < 8; r++) if (cnt_m[r] > 0) cand.push_back(r);
         if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
            retire_i      = 1'b1;
            retire_addr_i = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end else if ($urandom_range(0, 40) == 0) begin
            retire_i      = 1'b1;
            retire_addr_i = 5'($urandom_range(0, 7));
            if (issue_i && rd_write_i && retire_addr_i == rd_addr_i) retire_addr_i = 5'd0;
         end
         step($sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
